// File: rtl/sample_dac_pacer.sv
// Paces buffered audio samples out at a fixed rate and converts the playing
// sample to a 1-bit first-order sigma-delta bitstream.
module sample_dac_pacer #(
   parameter int unsigned CLK_DIV    = 1042,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned PREFILL    = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [31:0]                   asi_snk_data,
   input  logic                          asi_snk_valid,
   output logic                          asi_snk_ready,
   output logic [15:0]                   o_sample,
   output logic                          o_dac_out,
   output logic [$clog2(FIFO_DEPTH):0]   o_fill,
   output logic                          o_underflow
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned FW = AW + 1;
   localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [0:0] {
      ST_PREFILL = 1'b0,
      ST_RUN     = 1'b1
   } state_t;

   state_t          state;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [DW-1:0]   div_cnt;
   logic [15:0]     acc;
   logic [15:0]     mem [FIFO_DEPTH];

   logic            tick;
   logic            push;
   logic            pop;
   logic            empty;
   logic [16:0]     sd_sum;
   logic            unused_data_hi;

   assign unused_data_hi = ^asi_snk_data[31:16];

   assign asi_snk_ready = (o_fill != FW'(FIFO_DEPTH));
   assign push          = asi_snk_valid && asi_snk_ready;
   assign empty         = (o_fill == '0);
   assign tick          = (div_cnt == DW'(CLK_DIV - 1));
   assign pop           = tick && (state == ST_RUN) && !empty;

   // Offset-binary view of the playing sample; the carry out is the DAC bit.
   assign sd_sum = {1'b0, acc} + {1'b0, ~o_sample[15], o_sample[14:0]};

   // Sample storage: write port only, so it maps onto simple dual-port RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= asi_snk_data[15:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_PREFILL;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         o_fill      <= '0;
         div_cnt     <= '0;
         acc         <= '0;
         o_sample    <= '0;
         o_dac_out   <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + DW'(1);

         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end

         // Registered RAM read straight into the playing sample.
         if (pop) begin
            rd_ptr   <= rd_ptr + AW'(1);
            o_sample <= mem[rd_ptr];
         end

         case ({push, pop})
            2'b10:   o_fill <= o_fill + FW'(1);
            2'b01:   o_fill <= o_fill - FW'(1);
            default: o_fill <= o_fill;
         endcase

         case (state)
            ST_PREFILL: begin
               if (tick && (o_fill >= FW'(PREFILL))) begin
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (tick && empty) begin
                  state       <= ST_PREFILL;
                  o_underflow <= 1'b1;
               end
            end
            default: state <= ST_PREFILL;
         endcase

         acc       <= sd_sum[15:0];
         o_dac_out <= sd_sum[16];
      end
   end

endmodule

// File: tb/tb_sample_dac_pacer.sv
// Directed bench for sample_dac_pacer: fast-pacing instance for playback and
// DAC checks, slow-pacing instance for the back-pressure check.
module tb_sample_dac_pacer;

   localparam int unsigned FW = 5;

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic [31:0]   data;
   logic          valid;
   logic          ready;
   logic [15:0]   sample;
   logic          dac;
   logic [FW-1:0] fill;
   logic          uf;

   logic          b_reset;
   logic [31:0]   b_data;
   logic          b_valid;
   logic          b_ready;
   logic [15:0]   b_sample;
   logic          b_dac_unused;
   logic [FW-1:0] b_fill;
   logic          b_uf;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc++;

   sample_dac_pacer #(.CLK_DIV(4), .FIFO_DEPTH(16), .PREFILL(8)) u_dut (
      .clk           (clk),
      .reset         (reset),
      .asi_snk_data  (data),
      .asi_snk_valid (valid),
      .asi_snk_ready (ready),
      .o_sample      (sample),
      .o_dac_out     (dac),
      .o_fill        (fill),
      .o_underflow   (uf)
   );

   sample_dac_pacer #(.CLK_DIV(40), .FIFO_DEPTH(16), .PREFILL(8)) u_slow (
      .clk           (clk),
      .reset         (b_reset),
      .asi_snk_data  (b_data),
      .asi_snk_valid (b_valid),
      .asi_snk_ready (b_ready),
      .o_sample      (b_sample),
      .o_dac_out     (b_dac_unused),
      .o_fill        (b_fill),
      .o_underflow   (b_uf)
   );

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One accepted beat; upper half carries junk that must be ignored.
   task automatic push(input logic [15:0] v);
      data  = {~v, v};
      valid = 1'b1;
      step();
      valid = 1'b0;
   endtask

   task automatic wait_change(input string tag, input logic [15:0] old, input int bound);
      int n = 0;
      while (sample === old && n < bound) begin
         step();
         n++;
      end
      chk({tag, "_timeout"}, 32'(sample !== old), 32'd1);
   endtask

   initial begin
      int tprev;
      int ones;
      int ef;
      int n;
      logic [15:0] nv;

      reset   = 1'b0;
      valid   = 1'b0;
      data    = '0;
      b_reset = 1'b0;
      b_valid = 1'b0;
      b_data  = '0;
      repeat (3) step();
      chk("rst_fill",   32'(fill),   32'd0);
      chk("rst_sample", 32'(sample), 32'd0);
      chk("rst_dac",    32'(dac),    32'd0);
      chk("rst_uf",     32'(uf),     32'd0);

      // Idle after reset: silence is offset 0x8000, so the bitstream toggles.
      reset = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step();
         chk("idle_sample", 32'(sample), 32'd0);
         chk("idle_fill",   32'(fill),   32'd0);
         chk("idle_ready",  32'(ready),  32'd1);
         if (k <= 8) chk("idle_dac", 32'(dac), 32'(k % 2 == 0));
      end

      // Prefill then in-order playback, one sample per 4 cycles.
      for (int v = 1; v <= 8; v++) push(16'(v));
      chk("prefill_fill",  32'(fill),  32'd8);
      chk("prefill_ready", 32'(ready), 32'd1);
      wait_change("first_pop", 16'h0000, 20);
      chk("first_sample", 32'(sample), 32'h0001);
      chk("first_fill",   32'(fill),   32'd7);
      tprev = cyc;
      for (int v = 2; v <= 8; v++) begin
         wait_change("play", 16'(v - 1), 8);
         chk("play_sample", 32'(sample), 32'(v));
         chk("play_period", 32'(cyc - tprev), 32'd4);
         tprev = cyc;
      end

      // Underflow on the tick after the last sample; hold and re-prefill.
      repeat (3) step();
      chk("uf_before", 32'(uf), 32'd0);
      step();
      chk("uf_set",  32'(uf),     32'd1);
      chk("uf_hold", 32'(sample), 32'h0008);
      for (int i = 0; i < 7; i++) push(16'h7FFF);
      repeat (12) step();
      chk("no_resume_sample", 32'(sample), 32'h0008);
      chk("no_resume_fill",   32'(fill),   32'd7);
      push(16'h7FFF);
      wait_change("resume", 16'h0008, 20);
      chk("resume_sample", 32'(sample), 32'h7FFF);
      chk("uf_sticky",     32'(uf),     32'd1);

      // Full-scale positive: at most one zero in any 65536-cycle window.
      repeat (40) step();
      chk("hold_7fff", 32'(sample), 32'h7FFF);
      ones = 0;
      repeat (256) begin
         step();
         ones += int'(dac);
      end
      chk("dac_7fff_ones_ge_255", 32'(ones >= 255), 32'd1);

      // Full-scale negative: bitstream stays low.
      for (int i = 0; i < 8; i++) push(16'h8000);
      wait_change("neg", 16'h7FFF, 20);
      chk("neg_sample", 32'(sample), 32'h8000);
      repeat (2) step();
      ones = 0;
      repeat (64) begin
         step();
         ones += int'(dac);
      end
      chk("dac_8000_ones", 32'(ones), 32'd0);

      // Push landing on a pop tick keeps the fill level.
      for (int v = 16'h0101; v <= 16'h0108; v++) push(16'(v));
      wait_change("sim_first", 16'h8000, 20);
      chk("sim_first_sample", 32'(sample), 32'h0101);
      for (int v = 16'h0102; v <= 16'h0107; v++) begin
         wait_change("sim_play", 16'(v - 1), 8);
         chk("sim_play_sample", 32'(sample), 32'(v));
      end
      repeat (3) step();
      chk("sim_fill_before", 32'(fill), 32'd1);
      push(16'h0109);
      chk("sim_fill_after", 32'(fill),   32'd1);
      chk("sim_pop_sample", 32'(sample), 32'h0108);
      wait_change("sim_last", 16'h0108, 8);
      chk("sim_pushed_sample", 32'(sample), 32'h0109);
      chk("sim_drained",       32'(fill),   32'd0);

      // Reset mid-stream discards buffered data in one cycle.
      push(16'h0201);
      push(16'h0202);
      push(16'h0203);
      chk("pre_rst_fill", 32'(fill), 32'd3);
      reset = 1'b0;
      step();
      chk("mid_rst_fill",   32'(fill),   32'd0);
      chk("mid_rst_sample", 32'(sample), 32'd0);
      chk("mid_rst_uf",     32'(uf),     32'd0);
      reset = 1'b1;
      step();
      chk("post_rst_ready", 32'(ready), 32'd1);
      repeat (16) step();
      chk("post_rst_sample", 32'(sample), 32'd0);
      chk("post_rst_fill",   32'(fill),   32'd0);

      // Back-pressure on the slow instance: no tick within the first 39 cycles.
      step();
      b_reset = 1'b1;
      ef = 0;
      nv = 16'h0001;
      for (int i = 0; i < 24; i++) begin
         chk("bp_fill",  32'(b_fill),  32'(ef));
         chk("bp_ready", 32'(b_ready), 32'(ef != 16));
         b_data  = {16'hDEAD, nv};
         b_valid = 1'b1;
         step();
         if (ef < 16) begin
            ef++;
            nv++;
         end
      end
      n = 0;
      while (b_sample === 16'h0000 && n < 100) begin
         step();
         n++;
      end
      chk("bp_pop_timeout", 32'(b_sample !== 16'h0000), 32'd1);
      chk("bp_pop_sample",  32'(b_sample), 32'h0001);
      chk("bp_pop_fill",    32'(b_fill),   32'd15);
      chk("bp_pop_ready",   32'(b_ready),  32'd1);
      step();
      b_valid = 1'b0;
      chk("bp_refill_fill",  32'(b_fill),  32'd16);
      chk("bp_refill_ready", 32'(b_ready), 32'd0);
      n = 0;
      while (b_sample === 16'h0001 && n < 60) begin
         step();
         n++;
      end
      chk("bp_second_sample", 32'(b_sample), 32'h0002);
      chk("bp_uf",            32'(b_uf),     32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
